bit_stuffing: RTL and testbench
===============================

// Module: bit_stuffing
// PURPOSE
//  Transmit-side counterpart of unstuffing: serialises a packet bit stream, appends a 16-bit
//  CRC (LSB first), and inserts a 0 after every STUFF_LEN consecutive 1s on the line.
//  Sits between the packet serialiser/CRC generator and the line driver (NRZI/PHY).
//  Stuff insertion back-pressures the upstream source through in_ready.
// PARAMETERS
//  STUFF_LEN  6   consecutive output 1s that force one inserted 0
//  CRC_W      16  CRC field width appended after the last payload bit
//  IDLE_BIT   1   line level driven on data_out when no bit is being sent
// PORTS
//  clk        in   1      clock, all flops posedge
//  rst        in   1      asynchronous, active-low reset
//  en_stuf    in   1      block enable; low = synchronous abort/hold-in-idle
//  data_in    in   1      payload bit from upstream
//  in_valid   in   1      data_in/in_last valid this cycle
//  in_last    in   1      data_in is the final payload bit of the packet
//  in_ready   out  1      block accepts data_in this cycle (combinational)
//  crc_in     in   CRC_W  packet CRC, sampled on the in_last handshake
//  data_out   out  1      registered line bit (payload, CRC or stuff bit)
//  data_valid out  1      data_out carries a packet bit this cycle
//  busy       out  1      high from first accepted bit until trailing stuff bit/CRC done
// BEHAVIOUR
//  Reset (rst=0): state=IDLE, ones_cnt=0, crc_idx=0, stuff_pend=0, data_out=IDLE_BIT,
//   data_valid=0, busy=0; in_ready=0 because it is gated by en_stuf/state.
//  Handshake: bit accepted when in_valid && in_ready; emitted on data_out next cycle (latency 1).
//  in_ready = en_stuf && !stuff_pend && (state==IDLE || state==DATA).
//  ones_cnt (width clog2(STUFF_LEN+1)): +1 when an emitted bit is 1, cleared on emitted 0
//   (payload, CRC or stuff). When the emitted bit brings ones_cnt to STUFF_LEN, stuff_pend=1.
//  stuff_pend cycle: data_out<=0, data_valid<=1, ones_cnt<=0, stuff_pend<=0; no input accepted,
//   crc_idx does not advance. Stuff has priority over every other source.
//  FSM:
//   IDLE: data_valid<=0, data_out<=IDLE_BIT. Handshake -> emit bit, busy<=1;
//         in_last ? (latch crc_in, crc_idx<=0, ->CRC) : ->DATA.
//   DATA: handshake -> emit bit; in_last -> latch crc_in, crc_idx<=0, ->CRC.
//         in_valid=0 (underrun): data_valid<=0, data_out holds, ones_cnt held (run continues).
//   CRC:  if !stuff_pend emit crc_q[crc_idx], crc_idx+1; after bit CRC_W-1 -> DONE.
//   DONE: if stuff_pend, emit trailing stuff bit first (stuffing applies to the final CRC bit);
//         then ->IDLE, busy<=0, data_valid<=0, data_out<=IDLE_BIT, ones_cnt<=0.
//  Back-to-back packets: next packet accepted only in IDLE (minimum one idle cycle after DONE).
//  en_stuf=0 (any state, incl. mid-packet): next cycle state=IDLE, all counters/flags cleared,
//   data_valid=0, data_out=IDLE_BIT, busy=0; partial packet dropped, no CRC sent.
//  Async rst mid-packet: same as reset values immediately; no partial bits emitted after.
//  Boundary: in_last on a bit that completes a 1-run -> stuff bit precedes CRC bit 0;
//   CRC bits count into the same ones run as payload; 1-bit packet legal.
//  Invariant: line never carries more than STUFF_LEN consecutive 1s while data_valid=1.
// TESTING
//  1) Payload 8'b0101_0011 (LSB first), crc_in=16'h0000 -> 24 valid bits, no stuff, busy 24 cycles.
//  2) Payload 7 ones, in_last on 7th -> out 1,1,1,1,1,1,0,1 then CRC; in_ready low in stuff cycle.
//  3) Payload 8'h00, crc_in=16'hFFFF -> CRC bits stuffed after 6th and 12th 1s, trailing stuff
//     after bit 15? no: run of 4 -> 18 CRC-phase valid bits, 26 total.
//  4) Payload 1,1,1, in_valid gap 5 cycles, then 1,1,1 -> data_valid low during gap,
//     stuff 0 emitted after 6th 1 (run preserved across gap).
//  5) en_stuf dropped after 10 payload bits -> next cycle data_valid=0, data_out=1, busy=0;
//     new packet afterwards starts with ones_cnt=0.
//  6) rst pulsed low mid-CRC -> outputs at reset values immediately; checker confirms no
//     >STUFF_LEN run of 1s with data_valid=1 across all tests (unstuffing loopback matches).

Source files
------------

// File: rtl/bit_stuffing.sv
`timescale 1ns/1ps
// Serialises payload bits, appends CRC_W CRC bits LSB first, inserts a 0 after every STUFF_LEN consecutive 1s.
// Latency: one cycle from the in_valid/in_ready handshake to data_out.
// Backpressure: in_ready drops during stuff cycles, the CRC phase and the DONE cycle.
module bit_stuffing #(
    parameter int   STUFF_LEN = 6,
    parameter int   CRC_W     = 16,
    parameter logic IDLE_BIT  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_stuf,
    input  logic             data_in,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic [CRC_W-1:0] crc_in,
    output logic             data_out,
    output logic             data_valid,
    output logic             busy
);

    localparam int CW = $clog2(STUFF_LEN + 1);
    localparam int IW = $clog2(CRC_W);

    typedef enum logic [1:0] {IDLE, DATA, CRC, DONE} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    ones_cnt, ones_n;
    logic [IW-1:0]    crc_idx, idx_n;
    logic             stuff_pend, stuff_n;
    logic [CRC_W-1:0] crc_q, crc_n;
    logic             dout_n, dval_n, busy_n;
    logic             emit, ebit, hs;

    assign in_ready = en_stuf && !stuff_pend && (state == IDLE || state == DATA);
    assign hs       = in_valid && in_ready;

    always_comb begin
        state_n = state;
        ones_n  = ones_cnt;
        idx_n   = crc_idx;
        stuff_n = stuff_pend;
        crc_n   = crc_q;
        dout_n  = data_out;
        dval_n  = 1'b0;
        busy_n  = busy;
        emit    = 1'b0;
        ebit    = 1'b0;

        if (!en_stuf) begin
            state_n = IDLE;
            ones_n  = '0;
            idx_n   = '0;
            stuff_n = 1'b0;
            dout_n  = IDLE_BIT;
            busy_n  = 1'b0;
        end else if (stuff_pend) begin
            // Stuff bit wins over every source; the FSM simply waits one cycle.
            dout_n  = 1'b0;
            dval_n  = 1'b1;
            ones_n  = '0;
            stuff_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dout_n = IDLE_BIT;
                    if (hs) begin
                        emit   = 1'b1;
                        ebit   = data_in;
                        busy_n = 1'b1;
                        if (in_last) begin
                            crc_n   = crc_in;
                            idx_n   = '0;
                            state_n = CRC;
                        end else begin
                            state_n = DATA;
                        end
                    end
                end
                DATA: begin
                    // Underrun keeps data_out and the ones run untouched.
                    if (hs) begin
                        emit = 1'b1;
                        ebit = data_in;
                        if (in_last) begin
                            crc_n   = crc_in;
                            idx_n   = '0;
                            state_n = CRC;
                        end
                    end
                end
                CRC: begin
                    emit  = 1'b1;
                    ebit  = crc_q[crc_idx];
                    idx_n = crc_idx + IW'(1);
                    if (crc_idx == IW'(CRC_W - 1)) begin
                        state_n = DONE;
                    end
                end
                DONE: begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    dout_n  = IDLE_BIT;
                    ones_n  = '0;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        if (emit) begin
            dout_n = ebit;
            dval_n = 1'b1;
            if (ebit) begin
                if (ones_cnt == CW'(STUFF_LEN - 1)) begin
                    ones_n  = CW'(STUFF_LEN);
                    stuff_n = 1'b1;
                end else begin
                    ones_n = ones_cnt + CW'(1);
                end
            end else begin
                ones_n = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ones_cnt   <= '0;
            crc_idx    <= '0;
            stuff_pend <= 1'b0;
            crc_q      <= '0;
            data_out   <= IDLE_BIT;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            ones_cnt   <= ones_n;
            crc_idx    <= idx_n;
            stuff_pend <= stuff_n;
            crc_q      <= crc_n;
            data_out   <= dout_n;
            data_valid <= dval_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_bit_stuffing.sv
`timescale 1ns/1ps
// Bench for bit_stuffing: vector table, corner-case sequences and random packets vs a stuffing model.
module tb_bit_stuffing;

    localparam int SL = 6;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst, en_stuf, data_in, in_valid, in_last;
    logic [CW-1:0] crc_in;
    logic          in_ready, data_out, data_valid, busy;

    bit_stuffing #(.STUFF_LEN(SL), .CRC_W(CW), .IDLE_BIT(1'b1)) dut (
        .clk(clk), .rst(rst), .en_stuf(en_stuf), .data_in(data_in),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .crc_in(crc_in), .data_out(data_out), .data_valid(data_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pay;
        int          len;
        logic [15:0] crc;
        int          exp_cnt;
        int          exp_stall;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    bit pay_q[$];
    int gap_q[$];
    bit raw_q[$];
    bit exp_q[$];
    bit got[$];
    int busy_cyc  = 0;
    int inval_cyc = 0;
    int run       = 0;
    int max_run   = 0;
    int stall_cnt;
    int last_cnt, last_busy, last_inval;

    // Line monitor: collects valid bits and tracks the longest valid run of 1s within a packet.
    always @(posedge clk) begin
        #1;
        if (busy) busy_cyc++;
        if (busy && !data_valid) inval_cyc++;
        if (data_valid) begin
            got.push_back(data_out);
            run = data_out ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end else if (!busy) begin
            run = 0;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic build_exp(input logic [CW-1:0] c);
        int r;
        raw_q = pay_q;
        for (int i = 0; i < CW; i++) raw_q.push_back(c[i]);
        exp_q.delete();
        r = 0;
        foreach (raw_q[i]) begin
            exp_q.push_back(raw_q[i]);
            r = raw_q[i] ? r + 1 : 0;
            if (r == SL) begin
                exp_q.push_back(1'b0);
                r = 0;
            end
        end
    endtask

    task automatic zero_gaps();
        gap_q.delete();
        foreach (pay_q[i]) gap_q.push_back(0);
    endtask

    task automatic drive_pkt(input logic [CW-1:0] c, input bit set_last);
        int tries;
        stall_cnt = 0;
        for (int i = 0; i < pay_q.size(); i++) begin
            repeat (gap_q[i]) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            @(negedge clk);
            data_in  = pay_q[i];
            in_valid = 1'b1;
            in_last  = set_last && (i == pay_q.size() - 1);
            crc_in   = c;
            tries    = 0;
            while (!in_ready && tries < 50) begin
                stall_cnt++;
                @(negedge clk);
                tries++;
            end
            if (!in_ready) begin
                chk("in_ready timeout", 0, 1);
                break;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_pkt(input string nm, input logic [CW-1:0] c);
        int g0, b0, i0, t, bad, k, r;
        bit u[$];
        g0 = got.size();
        b0 = busy_cyc;
        i0 = inval_cyc;
        build_exp(c);
        drive_pkt(c, 1'b1);
        t = 0;
        while (busy && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (busy) chk({nm, " done timeout"}, 0, 1);
        last_cnt   = got.size() - g0;
        last_busy  = busy_cyc - b0;
        last_inval = inval_cyc - i0;
        chk({nm, " bit count"}, last_cnt, exp_q.size());
        bad = -1;
        for (int j = 0; j < exp_q.size() && j < last_cnt; j++)
            if (bad < 0 && got[g0 + j] !== exp_q[j]) bad = j;
        chk({nm, " first bad bit index"}, bad, -1);
        // Unstuff the captured line bits and compare against payload+CRC.
        r = 0;
        k = g0;
        while (k < got.size()) begin
            u.push_back(got[k]);
            r = got[k] ? r + 1 : 0;
            k++;
            if (r == SL) begin
                k++;
                r = 0;
            end
        end
        bad = (u.size() == raw_q.size()) ? -1 : -2;
        for (int j = 0; j < u.size() && j < raw_q.size(); j++)
            if (bad == -1 && u[j] !== raw_q[j]) bad = j;
        chk({nm, " unstuff loopback"}, bad, -1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[7];
        int   v0;
        vt[0] = '{16'h0053, 8,  16'h0000, 24, 0};
        vt[1] = '{16'h007F, 7,  16'h0000, 24, 1};
        vt[2] = '{16'h0000, 8,  16'hFFFF, 26, 0};
        vt[3] = '{16'h0001, 1,  16'h001F, 18, 0};
        vt[4] = '{16'h0000, 8,  16'hFC00, 25, 0};
        vt[5] = '{16'hFFFF, 16, 16'h0000, 34, 2};
        vt[6] = '{16'h003F, 6,  16'hFFFF, 25, 0};

        rst = 1'b0; en_stuf = 1'b0; data_in = 1'b0; in_valid = 1'b0; in_last = 1'b0; crc_in = '0;
        repeat (3) @(negedge clk);
        chk("reset data_valid", data_valid, 0);
        chk("reset data_out", data_out, 1);
        chk("reset busy", busy, 0);
        chk("reset in_ready", in_ready, 0);
        rst = 1'b1;
        en_stuf = 1'b1;
        @(negedge clk);
        chk("idle data_out", data_out, 1);
        chk("idle in_ready", in_ready, 1);

        for (int n = 0; n < 7; n++) begin
            pay_q.delete();
            for (int i = 0; i < vt[n].len; i++) pay_q.push_back(vt[n].pay[i]);
            zero_gaps();
            run_pkt($sformatf("vec%0d", n), vt[n].crc);
            chk($sformatf("vec%0d total bits", n), last_cnt, vt[n].exp_cnt);
            chk($sformatf("vec%0d busy cycles", n), last_busy, vt[n].exp_cnt);
            chk($sformatf("vec%0d in_ready stalls", n), stall_cnt, vt[n].exp_stall);
        end

        // Underrun gap in the middle of a 1-run: run must survive the gap.
        pay_q = '{1, 1, 1, 1, 1, 1};
        gap_q = '{0, 0, 0, 5, 0, 0};
        run_pkt("gap", 16'h0000);
        chk("gap total bits", last_cnt, 23);
        chk("gap invalid cycles", last_inval, 5);

        // Abort via en_stuf after 10 payload bits, ending on a partial 1-run.
        pay_q = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
        zero_gaps();
        drive_pkt(16'h0000, 1'b0);
        en_stuf = 1'b0;
        #1;
        chk("abort in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        chk("abort data_valid", data_valid, 0);
        chk("abort data_out", data_out, 1);
        chk("abort busy", busy, 0);
        v0 = got.size();
        repeat (4) @(negedge clk);
        chk("abort no CRC bits", got.size() - v0, 0);
        en_stuf = 1'b1;
        pay_q = '{1, 1, 1, 1, 1, 0};
        zero_gaps();
        run_pkt("after abort", 16'h0000);
        chk("after abort total bits", last_cnt, 22);

        // Asynchronous reset in the middle of the CRC phase.
        pay_q = '{1, 0, 1, 1};
        zero_gaps();
        drive_pkt(16'hA5A5, 1'b1);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst data_valid", data_valid, 0);
        chk("arst data_out", data_out, 1);
        chk("arst busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        v0 = got.size();
        repeat (5) @(negedge clk);
        chk("arst no partial bits", got.size() - v0, 0);

        for (int n = 0; n < 40; n++) begin
            int len;
            len = $urandom_range(1, 24);
            pay_q.delete();
            gap_q.delete();
            for (int i = 0; i < len; i++) begin
                pay_q.push_back($urandom_range(0, 3) != 0);
                gap_q.push_back(($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
            end
            run_pkt($sformatf("rand%0d", n), 16'($urandom));
        end

        chk("ones run exceeds STUFF_LEN", int'(max_run > SL), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
